rom_addr_sequencer: RTL and testbench
=====================================

Name: rom_addr_sequencer

Overview:
Upstream address generator for the 4-entry pattern ROM that drives SEG and LED[7:5].
- Replaces the raw SWI[3:2] address with a registered address.
- Modes: manual switch address, timed auto-scan up, timed auto-scan down, and single-step on a switch edge.
- Runs on the board's divided clock. Also exports status pulses and the current mode for LED/LCD debug.

Parameters:
ADDR_WIDTH, 2, width of the ROM address; the address space is 2**ADDR_WIDTH entries.
HOLD_CYCLES, 4, clk_2 cycles each address is held in auto modes; must be >= 1.
CNT_WIDTH, 8, width of the hold counter; must satisfy HOLD_CYCLES <= 2**CNT_WIDTH.

Ports:
clk_2  in  1  system clock (divided board clock).
reset  in  1  synchronous, active-high reset.
mode  in  2  mode select: 00 MANUAL, 01 AUTO_UP, 10 AUTO_DOWN, 11 STEP.
manual_addr  in  ADDR_WIDTH  address used in MANUAL.
step  in  1  level input; its rising edge advances the address in STEP.
pause  in  1  freezes the auto modes while high.
addr  out  ADDR_WIDTH  registered ROM address.
addr_changed  out  1  one-cycle pulse in the cycle addr takes a new value.
wrap  out  1  one-cycle pulse on wrap-around (max->0 up, 0->max down).
state  out  2  current state encoding, same codes as mode.
hold_count  out  CNT_WIDTH  current hold counter value.

Behaviour:
- Clock and reset: one clock, clk_2. reset is synchronous and active-high and has priority over every other event.
- Reset values: addr=0, state=MANUAL, hold_count=0, addr_changed=0, wrap=0, internal step_d=0.
- State register:
  - state <= mode every cycle; mode is decoded with a one-cycle latency.
  - When mode != state (a mode change), that cycle only: hold_count <= 0; addr is held; no advance, no pulses.
- MANUAL:
  - addr <= manual_addr (1-cycle latency).
  - addr_changed = 1 when manual_addr != addr.
  - wrap = 0. hold_count stays 0.
- AUTO_UP, pause = 0:
  - If hold_count == HOLD_CYCLES-1: hold_count <= 0, addr <= addr+1 mod 2**ADDR_WIDTH, addr_changed = 1. wrap = 1 if the old addr is all ones.
  - Otherwise hold_count <= hold_count+1.
- AUTO_DOWN: same as AUTO_UP but addr-1 mod 2**ADDR_WIDTH. wrap = 1 if the old addr == 0.
- pause = 1 in AUTO modes: addr and hold_count frozen, pulses 0. pause is ignored in the other modes.
- HOLD_CYCLES = 1: addr advances every cycle in AUTO modes.
- STEP:
  - Advance when step & ~step_d: addr+1 mod 2**ADDR_WIDTH, addr_changed = 1, wrap as in AUTO_UP.
  - hold_count stays 0.
- Step edge tracking:
  - step_d <= step every cycle in every mode.
  - Entering STEP with step already high does not advance.
  - Step edges outside STEP are ignored.
- Output timing: addr_changed and wrap are registered and assert in the same cycle addr shows the new value.
- Reset mid-scan: the next cycle shows addr=0 and state=MANUAL. A later mode input resumes through the normal mode-change cycle.

Decomposition:
- Shared package: seq_mode_t enum (MANUAL=2'b00, AUTO_UP=2'b01, AUTO_DOWN=2'b10, STEP=2'b11), plus default ADDR_WIDTH and HOLD_CYCLES constants shared with the ROM stage.
- One natural sub-module: edge_detect (registered rising-edge detector on step), reusable for other switch inputs.
- The hold counter and state register stay inline.

Test Plan:
1. Reset=1 for 2 cycles, then mode=00, manual_addr=2'b10 -> after 1 cycle addr=2, addr_changed pulses 1 cycle; holding manual_addr gives no further pulses.
2. mode=01, HOLD_CYCLES=4, starting from addr=3 -> 1 mode-change cycle, then addr=0 four cycles later with wrap=1 and addr_changed=1; next change to 1 after another 4 cycles with wrap=0.
3. mode=10 from addr=0, with pause=1 for 3 cycles mid-hold -> addr=3 with wrap=1. The pause delays the next change by exactly 3 cycles, and hold_count is unchanged during the pause.
4. mode=11 entered with step=1 -> no advance. Then step 0->1 twice from addr=1 -> addr=2, then addr=3, one addr_changed pulse each; step held high gives no repeat.
5. reset=1 during AUTO_UP at addr=2, hold_count=2 -> next cycle addr=0, state=00, hold_count=0, no pulses.
6. Mode switched 01->10 in the same cycle hold_count reaches HOLD_CYCLES-1 -> no advance that cycle, hold_count=0, and the next change is a decrement after HOLD_CYCLES cycles.

Source files
------------

// File: rtl/rom_addr_sequencer_pkg.sv
// rom_addr_sequencer_pkg: shared mode encoding and default sizes for the pattern ROM path
package rom_addr_sequencer_pkg;
  typedef enum logic [1:0] {
    MANUAL    = 2'b00,
    AUTO_UP   = 2'b01,
    AUTO_DOWN = 2'b10,
    STEP      = 2'b11
  } seq_mode_t;
  localparam int DEF_ADDR_WIDTH = 2;
  localparam int DEF_HOLD_CYCLES = 4;
  localparam int DEF_CNT_WIDTH = 8;
endpackage

// File: rtl/rom_addr_sequencer_edge_detect.sv
// rom_addr_sequencer_edge_detect: registered rising-edge detector for a switch level
module rom_addr_sequencer_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic d_q;
  // remember last cycle's level so a held switch does not re-trigger
  always_ff @(posedge clk)
    if (rst) d_q <= 1'b0;
    else d_q <= d;
  assign rise = d & ~d_q;
endmodule

// File: rtl/rom_addr_sequencer.sv
// rom_addr_sequencer: registered ROM address with manual, timed up/down scan and single-step modes
module rom_addr_sequencer
  import rom_addr_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] manual_addr,
  input  logic                  step,
  input  logic                  pause,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  addr_changed,
  output logic                  wrap,
  output logic [1:0]            state,
  output logic [CNT_WIDTH-1:0]  hold_count
);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
  seq_mode_t state_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_inc, addr_dec;
  logic [CNT_WIDTH-1:0] hold_q;
  logic changed_q, wrap_q, step_rise, at_max, at_min, hold_done;
  rom_addr_sequencer_edge_detect u_step_edge (
    .clk  (clk_2),
    .rst  (reset),
    .d    (step),
    .rise (step_rise)
  );
  // neighbours of the current address and the wrap/hold-expiry conditions
  always_comb begin
    addr_inc  = addr_q + 1'b1;
    addr_dec  = addr_q - 1'b1;
    at_max    = &addr_q;
    at_min    = ~|addr_q;
    hold_done = hold_q == HOLD_LAST;
  end
  // mode register, address, hold counter and one-cycle status pulses
  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q   <= MANUAL;
      addr_q    <= '0;
      hold_q    <= '0;
      changed_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= seq_mode_t'(mode);
      changed_q <= 1'b0;
      wrap_q    <= 1'b0;
      if (mode != state_q) hold_q <= '0;
      else
        case (state_q)
          MANUAL: begin
            addr_q    <= manual_addr;
            changed_q <= manual_addr != addr_q;
            hold_q    <= '0;
          end
          AUTO_UP, AUTO_DOWN:
            if (!pause) begin
              if (hold_done) begin
                hold_q    <= '0;
                addr_q    <= state_q == AUTO_UP ? addr_inc : addr_dec;
                changed_q <= 1'b1;
                wrap_q    <= state_q == AUTO_UP ? at_max : at_min;
              end else hold_q <= hold_q + 1'b1;
            end
          STEP: begin
            hold_q <= '0;
            if (step_rise) begin
              addr_q    <= addr_inc;
              changed_q <= 1'b1;
              wrap_q    <= at_max;
            end
          end
          default: ;
        endcase
    end
  end
  assign addr         = addr_q;
  assign addr_changed = changed_q;
  assign wrap         = wrap_q;
  assign state        = state_q;
  assign hold_count   = hold_q;
endmodule

// File: tb/tb_rom_addr_sequencer.sv
// tb_rom_addr_sequencer: directed vector bench for rom_addr_sequencer
module tb_rom_addr_sequencer;
  typedef struct {
    logic       rst;
    logic [1:0] mode;
    logic [1:0] man;
    logic       stp;
    logic       pse;
    logic [1:0] ea;
    logic       ec;
    logic       ew;
    logic [1:0] es;
    logic [7:0] eh;
  } vec_t;

  logic clk_2 = 1'b0;
  logic reset = 1'b1;
  logic [1:0] mode = 2'b00;
  logic [1:0] manual_addr = 2'b00;
  logic step = 1'b0;
  logic pause = 1'b0;
  logic [1:0] addr, state;
  logic addr_changed, wrap;
  logic [7:0] hold_count;

  logic [1:0] h1_mode = 2'b00;
  logic [1:0] h1_addr, h1_state;
  logic h1_changed, h1_wrap;
  logic [7:0] h1_hold;

  int nvec = 0;
  int nerr = 0;

  always #5 clk_2 = ~clk_2;

  rom_addr_sequencer #(.ADDR_WIDTH(2), .HOLD_CYCLES(4), .CNT_WIDTH(8)) dut (
    .clk_2        (clk_2),
    .reset        (reset),
    .mode         (mode),
    .manual_addr  (manual_addr),
    .step         (step),
    .pause        (pause),
    .addr         (addr),
    .addr_changed (addr_changed),
    .wrap         (wrap),
    .state        (state),
    .hold_count   (hold_count)
  );

  rom_addr_sequencer #(.ADDR_WIDTH(2), .HOLD_CYCLES(1), .CNT_WIDTH(8)) dut_h1 (
    .clk_2        (clk_2),
    .reset        (reset),
    .mode         (h1_mode),
    .manual_addr  (2'b00),
    .step         (1'b0),
    .pause        (1'b0),
    .addr         (h1_addr),
    .addr_changed (h1_changed),
    .wrap         (h1_wrap),
    .state        (h1_state),
    .hold_count   (h1_hold)
  );

  function automatic vec_t mk(logic r, logic [1:0] m, logic [1:0] ma, logic s, logic p,
                              logic [1:0] a, logic c, logic w, logic [1:0] st, logic [7:0] h);
    vec_t v;
    v.rst = r; v.mode = m; v.man = ma; v.stp = s; v.pse = p;
    v.ea = a; v.ec = c; v.ew = w; v.es = st; v.eh = h;
    return v;
  endfunction

  task automatic run(input vec_t v, input string nm);
    reset = v.rst; mode = v.mode; manual_addr = v.man; step = v.stp; pause = v.pse;
    @(posedge clk_2);
    #1;
    nvec++;
    if (addr !== v.ea || addr_changed !== v.ec || wrap !== v.ew || state !== v.es || hold_count !== v.eh) begin
      nerr++;
      $display("FAIL %s: got addr=%0d chg=%0b wrap=%0b state=%0d hold=%0d, want addr=%0d chg=%0b wrap=%0b state=%0d hold=%0d",
               nm, addr, addr_changed, wrap, state, hold_count, v.ea, v.ec, v.ew, v.es, v.eh);
    end
  endtask

  task automatic run_h1(input logic [1:0] a, input logic c, input logic w, input string nm);
    @(posedge clk_2);
    #1;
    nvec++;
    if (h1_addr !== a || h1_changed !== c || h1_wrap !== w || h1_state !== 2'd1 || h1_hold !== 8'd0) begin
      nerr++;
      $display("FAIL %s: got addr=%0d chg=%0b wrap=%0b state=%0d hold=%0d, want addr=%0d chg=%0b wrap=%0b state=1 hold=0",
               nm, h1_addr, h1_changed, h1_wrap, h1_state, h1_hold, a, c, w);
    end
  endtask

  vec_t tbl[$];

  initial begin
    // reset, then manual address with a single change pulse
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 2, 0, 0, 2, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 2, 0, 0, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3, 0, 0, 3, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3, 0, 0, 3, 0, 0, 0, 0));
    // auto up from 3: mode-change cycle, wrap to 0, then 1
    tbl.push_back(mk(0, 1, 3, 0, 0, 3, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 3, 0, 0, 3, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 3, 0, 0, 3, 0, 0, 1, 2));
    tbl.push_back(mk(0, 1, 3, 0, 0, 3, 0, 0, 1, 3));
    tbl.push_back(mk(0, 1, 3, 0, 0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0, 1, 2));
    tbl.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0, 1, 3));
    tbl.push_back(mk(0, 1, 3, 0, 0, 1, 1, 0, 1, 0));
    // back to manual 0, then auto down with a 3-cycle pause
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 2, 0, 0, 0, 0, 0, 0, 2, 0));
    tbl.push_back(mk(0, 2, 0, 0, 0, 0, 0, 0, 2, 1));
    tbl.push_back(mk(0, 2, 0, 0, 0, 0, 0, 0, 2, 2));
    tbl.push_back(mk(0, 2, 0, 0, 1, 0, 0, 0, 2, 2));
    tbl.push_back(mk(0, 2, 0, 0, 1, 0, 0, 0, 2, 2));
    tbl.push_back(mk(0, 2, 0, 0, 1, 0, 0, 0, 2, 2));
    tbl.push_back(mk(0, 2, 0, 0, 0, 0, 0, 0, 2, 3));
    tbl.push_back(mk(0, 2, 0, 0, 0, 3, 1, 1, 2, 0));
    // manual 1, then step mode entered with step already high
    tbl.push_back(mk(0, 0, 1, 0, 0, 3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 3, 1, 1, 0, 1, 0, 0, 3, 0));
    tbl.push_back(mk(0, 3, 1, 1, 0, 1, 0, 0, 3, 0));
    tbl.push_back(mk(0, 3, 1, 0, 0, 1, 0, 0, 3, 0));
    tbl.push_back(mk(0, 3, 1, 1, 0, 2, 1, 0, 3, 0));
    tbl.push_back(mk(0, 3, 1, 1, 1, 2, 0, 0, 3, 0));
    tbl.push_back(mk(0, 3, 1, 0, 0, 2, 0, 0, 3, 0));
    tbl.push_back(mk(0, 3, 1, 1, 0, 3, 1, 0, 3, 0));
    tbl.push_back(mk(0, 3, 1, 1, 0, 3, 0, 0, 3, 0));
    tbl.push_back(mk(0, 3, 1, 0, 0, 3, 0, 0, 3, 0));
    tbl.push_back(mk(0, 3, 1, 1, 0, 0, 1, 1, 3, 0));
    foreach (tbl[i]) run(tbl[i], $sformatf("tbl[%0d]", i));

    // reset in the middle of an up-scan at addr=2, hold=2
    run(mk(0, 0, 2, 0, 0, 0, 0, 0, 0, 0), "rst_seq_mchg");
    run(mk(0, 0, 2, 0, 0, 2, 1, 0, 0, 0), "rst_seq_man2");
    run(mk(0, 1, 2, 0, 0, 2, 0, 0, 1, 0), "rst_seq_up0");
    run(mk(0, 1, 2, 0, 0, 2, 0, 0, 1, 1), "rst_seq_up1");
    run(mk(0, 1, 2, 0, 0, 2, 0, 0, 1, 2), "rst_seq_up2");
    run(mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 0), "rst_seq_reset");
    run(mk(0, 1, 2, 0, 0, 0, 0, 0, 1, 0), "rst_seq_resume");

    // mode change up->down on the expiring hold cycle
    run(mk(0, 1, 2, 0, 0, 0, 0, 0, 1, 1), "sw_seq_h1");
    run(mk(0, 1, 2, 0, 0, 0, 0, 0, 1, 2), "sw_seq_h2");
    run(mk(0, 1, 2, 0, 0, 0, 0, 0, 1, 3), "sw_seq_h3");
    run(mk(0, 2, 2, 0, 0, 0, 0, 0, 2, 0), "sw_seq_change");
    run(mk(0, 2, 2, 0, 0, 0, 0, 0, 2, 1), "sw_seq_d1");
    run(mk(0, 2, 2, 0, 0, 0, 0, 0, 2, 2), "sw_seq_d2");
    run(mk(0, 2, 2, 0, 0, 0, 0, 0, 2, 3), "sw_seq_d3");
    run(mk(0, 2, 2, 0, 0, 3, 1, 1, 2, 0), "sw_seq_dec");

    // HOLD_CYCLES=1 instance advances every cycle
    h1_mode = 2'b01;
    run_h1(0, 0, 0, "h1_mchg");
    run_h1(1, 1, 0, "h1_a1");
    run_h1(2, 1, 0, "h1_a2");
    run_h1(3, 1, 0, "h1_a3");
    run_h1(0, 1, 1, "h1_wrap");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
